lfsr_encrypt_engine: RTL and testbench
======================================

// Module: lfsr_encrypt_engine
// PURPOSE
//  Fixed-function LFSR encrypter; the transmit end of the message-decryption program.
//  On request it reads the plaintext and config bytes from shared data memory and builds a 64-byte padded frame.
//  It XORs each byte with a 7-bit LFSR state, prepends even-parity in bit 7, and writes the ciphertext back.
//  It sits beside top_level's DM as a second bus master, and produces the exact frames the decrypt program consumes.
// PARAMETERS
//  FRAME_LEN  64     ciphertext bytes per run
//  MSG_MAX    52     plaintext bytes read, at DM[0..MSG_MAX-1], space-padded
//  PRE_ADDR   61     DM address of pre_length (bits 3:0 used)
//  TAP_ADDR   62     DM address of LFSR tap pattern (bits 6:0 used)
//  SEED_ADDR  63     DM address of LFSR seed (bits 6:0 used)
//  OUT_BASE   64     ciphertext written to DM[OUT_BASE +: FRAME_LEN]
//  ADDR_W     8      DM address width
// PORTS
//  clk         in   1       system clock, rising edge
//  init_n      in   1       asynchronous active-low reset
//  req         in   1       high = hold idle; first cycle low after high = start
//  ack         out  1       run complete; stays high until req rises
//  dm_addr     out  ADDR_W  DM address, combinational read, synchronous write
//  dm_rd_data  in   8       DM read data for dm_addr, same cycle
//  dm_wr_en    out  1       DM write strobe
//  dm_wr_data  out  8       DM write data
// BEHAVIOUR
//  Reset: state=IDLE; ack, dm_wr_en, dm_addr, dm_wr_data, lfsr, idx, armed all 0. Async assert, sync release.
//  Start rule
//   - armed is set while req=1.
//   - In IDLE, armed=1 and req=0 -> LD_PRE; armed clears.
//   - A fresh req high is required per run.
//  FSM
//   - IDLE -> LD_PRE -> LD_TAP -> LD_SEED -> {RD -> WR} x FRAME_LEN -> DONE.
//   - LD_*: drive the config address, latch dm_rd_data on the clock edge.
//   - A seed of 0 latches as 7'h01, since an all-zero LFSR would lock up.
//   - idx (6b) starts at 0.
//  RD(idx): drive dm_addr and latch the padded byte p. Define k = idx - pre (7b signed).
//   - k in [0, MSG_MAX-1]: dm_addr = k, p = dm_rd_data - 8'h20 (mod 256).
//   - Otherwise: dm_addr = 0, p = 8'h00 (space).
//  WR(idx): dm_wr_en = 1, dm_addr = OUT_BASE + idx.
//   - c[6:0] = p[6:0] ^ lfsr; c[7] = ^c[6:0].
//   - On the same clock edge: lfsr <= {lfsr[5:0], ^(lfsr & tap)} and idx <= idx + 1.
//   - After idx = FRAME_LEN-1: go to DONE.
//  Output timing
//   - dm_wr_en is high only in WR states, exactly FRAME_LEN pulses per run.
//   - Frame byte 0 uses the unstepped seed.
//  Latency: with the start-sampling edge at cycle 0, ack rises at cycle 3 + 2*FRAME_LEN + 1 = 132.
//  DONE: ack = 1 and no bus activity; req rising -> IDLE, ack = 0 next cycle.
//  Abort cases
//   - req rising during any non-IDLE state: abort to IDLE next cycle, no further writes.
//     Bytes already written stay in DM.
//   - init_n low mid-run: immediate reset, in-flight write suppressed.
//  pre_length: bits 3:0 used as-is (0..15).
//   - Plaintext bytes whose frame position >= FRAME_LEN are dropped.
//   - Positions past the message end are encrypted spaces.
//  Bit 7 of p and bit 7 of tap/seed are ignored. Parity is recomputed, never passed through.
// STRUCTURE
//  Package crypt_pkg
//   - enum state_t {IDLE, LD_PRE, LD_TAP, LD_SEED, RD, WR, DONE}.
//   - SPACE = 8'h20.
//   - LFSR_PTRN[9] = {60,48,78,72,6A,69,5C,7E,7B}.
//   - function lfsr7_next(state, tap).
//  Sub-module lfsr7: 7b register with load (seed, zero->1), step, and q.
//  Everything else (FSM, idx, pre/tap latches, address mux) stays in lfsr_encrypt_engine.
// TESTING
//  1. Basic frame: tap 0x6A, seed 0x39, pre 10, plaintext at DM[0..51].
//     -> DM[64] = 0x39, DM[65] = 0x72.
//     -> all 64 bytes match the golden model; ack at cycle 132.
//  2. Seed 0, tap 0x60, pre 10, all-space plaintext -> DM[64] = 0x81 (seed forced to 1, parity set).
//  3. Decrypt round trip: pre 15, 52-char message.
//     -> last 3 plaintext chars dropped; DM[127] = enc(p = DM[48] - 0x20).
//     -> decrypting with the same tap/seed restores the frame.
//  4. Abort: req raised at cycle 40.
//     -> no writes after cycle 41; ack stays 0.
//     -> a following clean run gives the full correct frame.
//  5. Reset mid-run: init_n low at cycle 70, held for 3 cycles.
//     -> all outputs 0 that cycle, FSM in IDLE.
//     -> no start until req goes 1 then 0.
//  6. Sweep all 9 LFSR_PTRN entries x seeds {0x01, 0x7F}.
//     -> every byte has even parity over [7:0].
//     -> exactly 64 dm_wr_en pulses per run.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared types and constants for the LFSR frame encrypter.
// Also holds the LFSR step function used by lfsr7.
package crypt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_PRE,
    LD_TAP,
    LD_SEED,
    RD,
    WR,
    DONE
  } state_t;

  localparam int FRAME_LEN = 64;
  localparam int MSG_MAX   = 52;
  localparam int PRE_ADDR  = 61;
  localparam int TAP_ADDR  = 62;
  localparam int SEED_ADDR = 63;
  localparam int OUT_BASE  = 64;
  localparam int ADDR_W    = 8;

  localparam logic [7:0] SPACE = 8'h20;

  localparam logic [7:0] LFSR_PTRN [9] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A,
    8'h69, 8'h5C, 8'h7E, 8'h7B
  };

  function automatic logic [6:0] lfsr7_next(
    input logic [6:0] state,
    input logic [6:0] tap
  );
    return {state[5:0], ^(state & tap)};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with seed load and single step.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr7
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] seed,
  input  logic [6:0] tap,
  output logic [6:0] q
);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      q <= '0;
    end else if (load) begin
      q <= (seed == 7'h00) ? 7'h01 : seed;
    end else if (step) begin
      q <= lfsr7_next(q, tap);
    end
  end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Reads plaintext and config from DM, writes a 64-byte
// LFSR-encrypted, even-parity frame back at OUT_BASE.
module lfsr_encrypt_engine
  import crypt_pkg::*;
(
  input  logic              clk,
  input  logic              init_n,
  input  logic              req,
  output logic              ack,
  output logic [ADDR_W-1:0] dm_addr,
  input  logic [7:0]        dm_rd_data,
  output logic              dm_wr_en,
  output logic [7:0]        dm_wr_data
);

  localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(PRE_ADDR);
  localparam logic [ADDR_W-1:0] A_TAP  = ADDR_W'(TAP_ADDR);
  localparam logic [ADDR_W-1:0] A_SEED = ADDR_W'(SEED_ADDR);
  localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(OUT_BASE);
  localparam logic [5:0] IDX_LAST = 6'(FRAME_LEN - 1);
  localparam logic [5:0] K_MAX    = 6'(MSG_MAX);

  state_t     state;
  state_t     state_n;
  logic       armed;
  logic [5:0] idx;
  logic [3:0] pre;
  logic [6:0] tap;
  logic [6:0] p;
  logic [6:0] lfsr;
  logic [6:0] k;
  logic [6:0] c;
  logic       in_msg;
  logic       abort;
  logic       wr_go;

  // armed is clear for the whole run, so req && !armed is its rising edge
  assign abort  = req && !armed && (state != IDLE);
  assign wr_go  = (state == WR) && !abort;
  assign k      = {1'b0, idx} - {3'b000, pre};
  assign in_msg = !k[6] && (k[5:0] < K_MAX);
  assign c      = 7'(p ^ {1'b0, lfsr});

  lfsr7 u_lfsr (
    .clk    (clk),
    .init_n (init_n),
    .load   (state == LD_SEED),
    .step   (wr_go),
    .seed   (dm_rd_data[6:0]),
    .tap    (tap),
    .q      (lfsr)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (armed && !req) state_n = LD_PRE;
      LD_PRE:  state_n = LD_TAP;
      LD_TAP:  state_n = LD_SEED;
      LD_SEED: state_n = RD;
      RD:      state_n = WR;
      WR:      state_n = (idx == IDX_LAST) ? DONE : RD;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_comb begin
    dm_addr    = '0;
    dm_wr_en   = 1'b0;
    dm_wr_data = '0;
    unique case (state)
      LD_PRE:  dm_addr = A_PRE;
      LD_TAP:  dm_addr = A_TAP;
      LD_SEED: dm_addr = A_SEED;
      RD:      dm_addr = in_msg ? {2'b00, k[5:0]} : '0;
      WR: begin
        dm_wr_en   = !abort;
        dm_addr    = A_OUT + {2'b00, idx};
        dm_wr_data = {^c, c};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state <= IDLE;
      armed <= 1'b0;
      ack   <= 1'b0;
      idx   <= '0;
      pre   <= '0;
      tap   <= '0;
      p     <= '0;
    end else begin
      state <= state_n;
      ack   <= (state == DONE) && !abort;
      if (req) begin
        armed <= 1'b1;
      end else if (state == IDLE) begin
        armed <= 1'b0;
      end
      if (state == IDLE) idx <= '0;
      if (wr_go) idx <= idx + 6'd1;
      if (state == LD_PRE) pre <= dm_rd_data[3:0];
      if (state == LD_TAP) tap <= dm_rd_data[6:0];
      // padding positions encrypt as a space, i.e. p = 0
      if (state == RD) begin
        p <= in_msg ? 7'(dm_rd_data - SPACE) : '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Directed + randomized bench for lfsr_encrypt_engine with a
// frame-level reference model and a behavioural data memory.
module tb_lfsr_encrypt_engine;
  import crypt_pkg::*;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;

  logic [7:0] dm [256];
  logic [7:0] msg [52];
  logic [7:0] expv [64];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int wr_count = 0;
  int last_wr_cyc = -1;

  lfsr_encrypt_engine dut (
    .clk        (clk),
    .init_n     (init_n),
    .req        (req),
    .ack        (ack),
    .dm_addr    (dm_addr),
    .dm_rd_data (dm_rd_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data)
  );

  always #5 clk = ~clk;

  assign dm_rd_data = dm[dm_addr];

  always @(posedge clk) cyc++;

  // write sampled mid-cycle; it lands on the next rising edge
  always @(negedge clk) begin
    if (dm_wr_en === 1'b1) begin
      dm[dm_addr] = dm_wr_data;
      wr_count++;
      last_wr_cyc = cyc + 1;
    end
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_msg(input bit spaces);
    for (int i = 0; i < 52; i++) begin
      if (spaces) msg[i] = 8'h20;
      else msg[i] = 8'($urandom_range(8'h20, 8'h7E));
    end
  endtask

  // frame built straight from the rules: pad, xor with stream, parity
  function automatic void model(
    input logic [3:0] pre,
    input logic [6:0] tap,
    input logic [6:0] seed
  );
    int s;
    int pos;
    int pv;
    int cv;
    s = (seed == 0) ? 1 : int'(seed);
    for (int i = 0; i < 64; i++) begin
      pos = i - int'(pre);
      pv = 0;
      if (pos >= 0 && pos < 52) pv = (int'(msg[pos]) - 32) & 127;
      cv = pv ^ s;
      expv[i] = 8'((($countones(cv) & 1) << 7) | cv);
      s = ((s << 1) & 127) | ($countones(s & int'(tap)) & 1);
    end
  endfunction

  task automatic load_dm(
    input logic [3:0] pre,
    input logic [7:0] tap,
    input logic [7:0] seed
  );
    for (int i = 0; i < 52; i++) dm[i] = msg[i];
    dm[61] = {4'($urandom), pre};
    dm[62] = tap;
    dm[63] = seed;
    for (int i = 64; i < 128; i++) dm[i] = 8'hEE;
    wr_count = 0;
    last_wr_cyc = -1;
  endtask

  task automatic kick(output int s);
    req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 s = cyc;
  endtask

  task automatic wait_ack(input int s, output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      if (ack === 1'b1) begin
        lat = cyc - s;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(
    input string      tag,
    input logic [3:0] pre,
    input logic [7:0] tap,
    input logic [7:0] seed
  );
    int s;
    int lat;
    int perr;
    load_dm(pre, tap, seed);
    model(pre, tap[6:0], seed[6:0]);
    kick(s);
    wait_ack(s, lat);
    check({tag, "_latency"}, lat, 132);
    check({tag, "_writes"}, wr_count, 64);
    perr = 0;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_byte%0d", tag, i), dm[64+i], expv[i]);
      if ($countones(dm[64+i]) % 2 != 0) perr++;
    end
    check({tag, "_parity_errs"}, perr, 0);
    repeat (3) @(posedge clk);
    #1 check({tag, "_ack_hold"}, ack, 1);
    req = 1'b1;
    @(posedge clk);
    #1 check({tag, "_ack_clear"}, ack, 0);
  endtask

  initial begin
    int s;
    int lat;
    int errs;
    int pv;
    int sd;
    int wc;
    bit ack_seen;
    logic [7:0] b;
    logic [7:0] seeds [2];

    for (int i = 0; i < 256; i++) dm[i] = 8'h00;
    seeds[0] = 8'h01;
    seeds[1] = 8'h7F;

    #1;
    check("rst_ack", ack, 0);
    check("rst_wr_en", dm_wr_en, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_wr_data", dm_wr_data, 0);
    repeat (3) @(posedge clk);
    #1 init_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("idle_no_start", wr_count, 0);

    rand_msg(1'b0);
    run_frame("basic", 4'd10, 8'h6A, 8'h39);
    check("basic_b64", dm[64], 8'h39);
    check("basic_b65", dm[65], 8'h72);

    rand_msg(1'b1);
    run_frame("seed0", 4'd10, 8'h60, 8'h00);
    check("seed0_b64", dm[64], 8'h81);

    rand_msg(1'b0);
    run_frame("pre15", 4'd15, 8'hEA, 8'hC5);
    sd = 8'h45;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      b = dm[64+i];
      if ($countones(b) % 2 != 0) errs++;
      pv = (int'(b) & 127) ^ sd;
      if (i >= 15) begin
        if (8'(pv + 32) != msg[i-15]) errs++;
      end else begin
        if (pv != 0) errs++;
      end
      sd = ((sd << 1) & 127) | ($countones(sd & 8'h6A) & 1);
    end
    check("pre15_decrypt_errs", errs, 0);
    pv = (int'(msg[48]) - 32) & 127;
    check("pre15_last_src", dm[127], expv[63]);

    rand_msg(1'b0);
    load_dm(4'd3, 8'h78, 8'h2B);
    kick(s);
    repeat (40) @(posedge clk);
    #1 req = 1'b1;
    ack_seen = 1'b0;
    repeat (150) begin
      @(posedge clk);
      #1 if (ack === 1'b1) ack_seen = 1'b1;
    end
    check("abort_late_write", (last_wr_cyc - s) <= 41, 1);
    check("abort_some_writes", wr_count > 0, 1);
    check("abort_ack", ack_seen, 0);
    check("abort_tail_untouched", dm[127], 8'hEE);
    run_frame("after_abort", 4'd3, 8'h78, 8'h2B);

    rand_msg(1'b0);
    load_dm(4'd7, 8'h5C, 8'h11);
    kick(s);
    repeat (70) @(posedge clk);
    #1 init_n = 1'b0;
    #1;
    check("rst_mid_ack", ack, 0);
    check("rst_mid_wr_en", dm_wr_en, 0);
    check("rst_mid_addr", dm_addr, 0);
    check("rst_mid_wr_data", dm_wr_data, 0);
    repeat (3) @(posedge clk);
    #1 init_n = 1'b1;
    wc = wr_count;
    check("rst_mid_writes", wc, 33);
    check("rst_mid_inflight", dm[97], 8'hEE);
    repeat (200) @(posedge clk);
    #1;
    check("rst_mid_no_start", wr_count, wc);
    check("rst_mid_no_ack", ack, 0);
    run_frame("after_reset", 4'd7, 8'h5C, 8'h11);

    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < 2; j++) begin
        rand_msg(1'b0);
        run_frame($sformatf("sweep%0d_%0d", t, j),
                  4'($urandom), LFSR_PTRN[t], seeds[j]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
